obi_varlat_one_to_n_demux: RTL and testbench

One-to-N OBI demultiplexer with variable-latency response routing: one `obi_pkg` initiator port fans out to `NSLAVE` responder ports selected by address range. It is the counterpart of the N-to-1 variable-latency crossbar that merges the external CPU's instruction, data and debug masters. It sits on the external-master side of the CPU subsystem and splits traffic between on-chip system memory and local subsystem resources. It tracks outstanding transactions so every response returns to the initiator in request order. Unmapped addresses are absorbed by an internal error responder.

---
 rtl/obi_pkg.sv | 20 ++
 rtl/obi_addr_decode.sv | 22 ++
 rtl/obi_varlat_one_to_n_demux.sv | 115 +++++++++++
 tb/tb_obi_varlat_one_to_n_demux.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_pkg.sv
// Shared OBI bus payload types and the error-responder read data constant.
package obi_pkg;

  localparam logic [31:0] OBI_ERR_RDATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_addr_decode.sv
// Address range compare with lowest-index priority; NSLAVE means no region hit.
module obi_addr_decode #(
  parameter int unsigned                NSLAVE     = 2,
  parameter logic [NSLAVE-1:0][31:0]    START_ADDR = '0,
  parameter logic [NSLAVE-1:0][31:0]    END_ADDR   = '0,
  localparam int unsigned               TGT_W      = $clog2(NSLAVE + 1)
) (
  input  logic [31:0]      addr_i,
  output logic [TGT_W-1:0] tgt_o
);

  // Walk from the highest index down so the lowest matching region wins.
  always_comb begin
    tgt_o = TGT_W'(NSLAVE);
    for (int i = int'(NSLAVE) - 1; i >= 0; i--) begin
      if (addr_i >= START_ADDR[i] && addr_i < END_ADDR[i]) begin
        tgt_o = TGT_W'(i);
      end
    end
  end

endmodule

// File: rtl/obi_varlat_one_to_n_demux.sv
// One-to-N OBI demux: in-order response routing via an outstanding counter and
// a single-target lock; unmapped accesses are answered by an internal responder.
module obi_varlat_one_to_n_demux
  import obi_pkg::*;
#(
  parameter int unsigned             NSLAVE          = 2,
  parameter int unsigned             MAX_OUTSTANDING = 2,
  parameter logic [NSLAVE-1:0][31:0] START_ADDR      = '0,
  parameter logic [NSLAVE-1:0][31:0] END_ADDR        = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  obi_req_t               master_req_i,
  output obi_resp_t              master_resp_o,
  output obi_req_t  [NSLAVE-1:0] slave_req_o,
  input  obi_resp_t [NSLAVE-1:0] slave_resp_i,
  output logic                   unmapped_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TGT_W = $clog2(NSLAVE + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TGT_W-1:0] cur_tgt_q, cur_tgt_d;
  logic             err_pend_q, err_pend_d;

  logic [TGT_W-1:0] tgt;
  logic             busy, accept, tgt_is_err, cur_is_err;
  logic             slv_gnt, slv_rvalid, gnt, rvalid;
  logic [31:0]      slv_rdata;
  logic             spurious_c;

  obi_addr_decode #(
    .NSLAVE     (NSLAVE),
    .START_ADDR (START_ADDR),
    .END_ADDR   (END_ADDR)
  ) u_decode (
    .addr_i (master_req_i.addr),
    .tgt_o  (tgt)
  );

  // Request fan-out, grant/response mux and next-state. Outputs are gated by
  // rst_ni so the whole port set reads zero while reset is held.
  always_comb begin
    busy       = (cnt_q != '0);
    tgt_is_err = (tgt == TGT_W'(NSLAVE));
    cur_is_err = (cur_tgt_q == TGT_W'(NSLAVE));
    accept     = rst_ni && master_req_i.req
                 && (cnt_q < CNT_W'(MAX_OUTSTANDING))
                 && (!busy || tgt == cur_tgt_q);

    slv_gnt    = 1'b0;
    slv_rvalid = 1'b0;
    slv_rdata  = '0;
    for (int i = 0; i < int'(NSLAVE); i++) begin
      slave_req_o[i] = '0;
      if (rst_ni && tgt == TGT_W'(i)) begin
        slave_req_o[i]     = master_req_i;
        slave_req_o[i].req = accept;
        slv_gnt            = slave_resp_i[i].gnt;
      end
      if (cur_tgt_q == TGT_W'(i)) begin
        slv_rvalid = slave_resp_i[i].rvalid;
        slv_rdata  = slave_resp_i[i].rdata;
      end
    end

    gnt    = accept && (tgt_is_err || slv_gnt);
    rvalid = busy && (cur_is_err ? err_pend_q : slv_rvalid);

    master_resp_o        = '0;
    master_resp_o.gnt    = gnt;
    master_resp_o.rvalid = rvalid;
    if (busy) begin
      master_resp_o.rdata = cur_is_err ? OBI_ERR_RDATA : slv_rdata;
    end
    unmapped_err_o = gnt && tgt_is_err;

    cnt_d = cnt_q;
    case ({gnt, rvalid})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    cur_tgt_d  = gnt ? tgt : cur_tgt_q;
    // The error responder always answers exactly one cycle after its grant.
    err_pend_d = gnt && tgt_is_err;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      cur_tgt_q  <= '0;
      err_pend_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_tgt_q  <= cur_tgt_d;
      err_pend_q <= err_pend_d;
    end
  end

  // A responder rvalid with nothing outstanding toward it is dropped.
  always_comb begin
    spurious_c = 1'b0;
    for (int i = 0; i < int'(NSLAVE); i++) begin
      if (slave_resp_i[i].rvalid && (!busy || cur_tgt_q != TGT_W'(i))) begin
        spurious_c = 1'b1;
      end
    end
  end

  a_spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni) !spurious_c)
    else $warning("a_spurious_rvalid: responder rvalid without a matching outstanding request");

endmodule

// File: tb/tb_obi_varlat_one_to_n_demux.sv
// Directed scenarios plus a randomized run checked against an in-order queue model.
module tb_obi_varlat_one_to_n_demux;
  import obi_pkg::*;

  localparam int unsigned NS   = 2;
  localparam int unsigned MAXO = 2;
  localparam logic [NS-1:0][31:0] S_A = {32'h0000_2000, 32'h0000_0000};
  localparam logic [NS-1:0][31:0] E_A = {32'h0000_3000, 32'h0000_1000};

  typedef struct { int due; logic [31:0] data; } rsp_t;

  logic                  clk;
  logic                  rst_n;
  obi_req_t              mreq;
  obi_resp_t             mresp;
  obi_req_t  [NS-1:0]    sreq;
  obi_resp_t [NS-1:0]    sresp;
  logic                  uerr;

  int n_cmp = 0;
  int n_err = 0;

  obi_varlat_one_to_n_demux #(
    .NSLAVE(NS), .MAX_OUTSTANDING(MAXO), .START_ADDR(S_A), .END_ADDR(E_A)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .master_req_i(mreq), .master_resp_o(mresp),
    .slave_req_o(sreq), .slave_resp_i(sresp), .unmapped_err_o(uerr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mreq  = '0;
    sresp = '0;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] a);
    mreq.req   = 1'b1;
    mreq.we    = we;
    mreq.be    = 4'hF;
    mreq.addr  = a;
    mreq.wdata = $urandom;
  endtask

  // Plain region lookup: 0 -> [0,0x1000), 1 -> [0x2000,0x3000), 2 -> error responder.
  function automatic int model_tgt(input logic [31:0] a);
    if (a < 32'h1000) return 0;
    if (a >= 32'h2000 && a < 32'h3000) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] pick_addr();
    logic [31:0] edges [8] = '{32'h0, 32'h0FFF, 32'h1000, 32'h1FFF,
                               32'h2000, 32'h2FFF, 32'h3000, 32'hFFFF_FFFC};
    case ($urandom_range(0, 4))
      0:       return edges[$urandom_range(0, 7)];
      1:       return 32'h4000 + 32'($urandom_range(0, 32'hFFF));
      2:       return 32'($urandom_range(0, 32'hFFF));
      default: return 32'h2000 + 32'($urandom_range(0, 32'hFFF));
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive_req(1'b0, 32'h10);
    sresp[0] = '{gnt: 1'b1, rvalid: 1'b1, rdata: 32'h1};
    sresp[1] = '{gnt: 1'b1, rvalid: 1'b1, rdata: 32'h2};
    #1;
    n_cmp++; if (sreq !== '0) begin n_err++; $display("FAIL rst_sreq: got %h want 0", sreq); end
    n_cmp++; if (mresp !== '0) begin n_err++; $display("FAIL rst_mresp: got %h want 0", mresp); end
    n_cmp++; if (uerr !== 1'b0) begin n_err++; $display("FAIL rst_uerr: got %b want 0", uerr); end
    next_cycle();
    idle();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (mresp !== '0) begin n_err++; $display("FAIL rst_release_mresp: got %h want 0", mresp); end
    next_cycle();
  endtask

  task automatic test_single_read();
    idle();
    drive_req(1'b0, 32'h10);
    sresp[0].gnt = 1'b1;
    #1;
    n_cmp++; if (mresp.gnt !== 1'b1) begin n_err++; $display("FAIL tp1_gnt: got %b want 1", mresp.gnt); end
    n_cmp++; if (sreq[0].req !== 1'b1) begin n_err++; $display("FAIL tp1_s0_req: got %b want 1", sreq[0].req); end
    n_cmp++; if (sreq[0].addr !== 32'h10) begin n_err++; $display("FAIL tp1_s0_addr: got %h want 10", sreq[0].addr); end
    n_cmp++; if (sreq[1].req !== 1'b0) begin n_err++; $display("FAIL tp1_s1_req: got %b want 0", sreq[1].req); end
    next_cycle();
    idle();
    for (int k = 1; k < 3; k++) begin
      #1;
      n_cmp++; if (mresp.rvalid !== 1'b0) begin n_err++; $display("FAIL tp1_early_rvalid k=%0d: got %b want 0", k, mresp.rvalid); end
      next_cycle();
    end
    sresp[0].rvalid = 1'b1;
    sresp[0].rdata  = 32'h1234_5678;
    #1;
    n_cmp++; if (mresp.rvalid !== 1'b1) begin n_err++; $display("FAIL tp1_rvalid: got %b want 1", mresp.rvalid); end
    n_cmp++; if (mresp.rdata !== 32'h1234_5678) begin n_err++; $display("FAIL tp1_rdata: got %h want 12345678", mresp.rdata); end
    next_cycle();
    idle();
  endtask

  task automatic test_back_to_back();
    logic        exp_gnt [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] dat [3];
    for (int k = 0; k < 3; k++) dat[k] = $urandom;
    idle();
    for (int c = 0; c < 7; c++) begin
      sresp[1].gnt = 1'b1;
      if (c < 6) drive_req(1'b0, 32'h2000); else mreq = '0;
      sresp[1].rvalid = (c >= 4);
      sresp[1].rdata  = (c >= 4) ? dat[c-4] : 32'h0;
      #1;
      n_cmp++; if (mresp.gnt !== exp_gnt[c]) begin n_err++; $display("FAIL b2b_gnt c=%0d: got %b want %b", c, mresp.gnt, exp_gnt[c]); end
      if (c >= 4) begin
        n_cmp++; if (mresp.rvalid !== 1'b1 || mresp.rdata !== dat[c-4]) begin n_err++; $display("FAIL b2b_rsp c=%0d: got %b/%h want 1/%h", c, mresp.rvalid, mresp.rdata, dat[c-4]); end
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_target_switch();
    logic [31:0] d0, d1;
    d0 = $urandom;
    d1 = $urandom;
    idle();
    drive_req(1'b0, 32'h10);
    sresp[0].gnt = 1'b1;
    #1;
    n_cmp++; if (mresp.gnt !== 1'b1) begin n_err++; $display("FAIL sw_first_gnt: got %b want 1", mresp.gnt); end
    next_cycle();
    sresp[0].gnt = 1'b0;
    sresp[1].gnt = 1'b1;
    drive_req(1'b0, 32'h2004);
    for (int c = 1; c < 7; c++) begin
      sresp[0].rvalid = (c == 5);
      sresp[0].rdata  = d0;
      #1;
      n_cmp++; if (mresp.gnt !== (c == 6)) begin n_err++; $display("FAIL sw_gnt c=%0d: got %b want %b", c, mresp.gnt, c == 6); end
      n_cmp++; if (sreq[1].req !== (c == 6)) begin n_err++; $display("FAIL sw_s1_req c=%0d: got %b want %b", c, sreq[1].req, c == 6); end
      if (c == 5) begin
        n_cmp++; if (mresp.rvalid !== 1'b1 || mresp.rdata !== d0) begin n_err++; $display("FAIL sw_rsp0: got %b/%h want 1/%h", mresp.rvalid, mresp.rdata, d0); end
      end
      next_cycle();
    end
    idle();
    sresp[1].rvalid = 1'b1;
    sresp[1].rdata  = d1;
    #1;
    n_cmp++; if (mresp.rvalid !== 1'b1 || mresp.rdata !== d1) begin n_err++; $display("FAIL sw_rsp1: got %b/%h want 1/%h", mresp.rvalid, mresp.rdata, d1); end
    next_cycle();
    idle();
  endtask

  task automatic test_unmapped();
    idle();
    drive_req(1'b1, 32'h5000);
    #1;
    n_cmp++; if (mresp.gnt !== 1'b1) begin n_err++; $display("FAIL um_gnt: got %b want 1", mresp.gnt); end
    n_cmp++; if (uerr !== 1'b1) begin n_err++; $display("FAIL um_pulse: got %b want 1", uerr); end
    n_cmp++; if (sreq[0].req !== 1'b0 || sreq[1].req !== 1'b0) begin n_err++; $display("FAIL um_sreq: got %b%b want 00", sreq[1].req, sreq[0].req); end
    next_cycle();
    idle();
    #1;
    n_cmp++; if (mresp.rvalid !== 1'b1 || mresp.rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL um_rsp: got %b/%h want 1/deadbeef", mresp.rvalid, mresp.rdata); end
    n_cmp++; if (uerr !== 1'b0) begin n_err++; $display("FAIL um_pulse_len: got %b want 0", uerr); end
    next_cycle();
    #1;
    n_cmp++; if (mresp.rvalid !== 1'b0) begin n_err++; $display("FAIL um_single_rsp: got %b want 0", mresp.rvalid); end
    next_cycle();
  endtask

  task automatic test_simultaneous();
    logic [31:0] x, y, z;
    x = $urandom; y = $urandom; z = $urandom;
    idle();
    drive_req(1'b0, 32'h10);
    sresp[0].gnt = 1'b1;
    #1;
    n_cmp++; if (mresp.gnt !== 1'b1) begin n_err++; $display("FAIL sim_gnt0: got %b want 1", mresp.gnt); end
    next_cycle();
    sresp[0].rvalid = 1'b1;
    sresp[0].rdata  = x;
    #1;
    n_cmp++; if (mresp.gnt !== 1'b1 || mresp.rvalid !== 1'b1 || mresp.rdata !== x) begin n_err++; $display("FAIL sim_both: got %b/%b/%h want 1/1/%h", mresp.gnt, mresp.rvalid, mresp.rdata, x); end
    next_cycle();
    drive_req(1'b0, 32'h2000);
    sresp[0].gnt   = 1'b0;
    sresp[1].gnt   = 1'b1;
    sresp[0].rdata = y;
    #1;
    n_cmp++; if (mresp.gnt !== 1'b0) begin n_err++; $display("FAIL sim_cnt_held: got gnt %b want 0", mresp.gnt); end
    n_cmp++; if (mresp.rvalid !== 1'b1 || mresp.rdata !== y) begin n_err++; $display("FAIL sim_rsp2: got %b/%h want 1/%h", mresp.rvalid, mresp.rdata, y); end
    next_cycle();
    sresp[0].rvalid = 1'b0;
    #1;
    n_cmp++; if (mresp.gnt !== 1'b1) begin n_err++; $display("FAIL sim_drained: got gnt %b want 1", mresp.gnt); end
    next_cycle();
    idle();
    sresp[1].rvalid = 1'b1;
    sresp[1].rdata  = z;
    #1;
    n_cmp++; if (mresp.rvalid !== 1'b1 || mresp.rdata !== z) begin n_err++; $display("FAIL sim_rsp3: got %b/%h want 1/%h", mresp.rvalid, mresp.rdata, z); end
    next_cycle();
    idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    d = $urandom;
    idle();
    drive_req(1'b0, 32'h10);
    sresp[0].gnt = 1'b1;
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (sreq !== '0) begin n_err++; $display("FAIL rm_sreq: got %h want 0", sreq); end
    n_cmp++; if (mresp !== '0) begin n_err++; $display("FAIL rm_mresp: got %h want 0", mresp); end
    n_cmp++; if (uerr !== 1'b0) begin n_err++; $display("FAIL rm_uerr: got %b want 0", uerr); end
    next_cycle();
    idle();
    rst_n = 1'b1;
    sresp[0].rvalid = 1'b1;
    sresp[0].rdata  = 32'hBAD0_BAD0;
    #1;
    n_cmp++; if (mresp.rvalid !== 1'b0) begin n_err++; $display("FAIL rm_stale_rvalid: got %b want 0", mresp.rvalid); end
    next_cycle();
    idle();
    drive_req(1'b0, 32'h2000);
    sresp[1].gnt = 1'b1;
    #1;
    n_cmp++; if (mresp.gnt !== 1'b1 || sreq[1].req !== 1'b1) begin n_err++; $display("FAIL rm_fresh_gnt: got %b/%b want 1/1", mresp.gnt, sreq[1].req); end
    next_cycle();
    idle();
    sresp[1].rvalid = 1'b1;
    sresp[1].rdata  = d;
    #1;
    n_cmp++; if (mresp.rvalid !== 1'b1 || mresp.rdata !== d) begin n_err++; $display("FAIL rm_fresh_rsp: got %b/%h want 1/%h", mresp.rvalid, mresp.rdata, d); end
    next_cycle();
    idle();
  endtask

  // Model: oq holds the targets of accepted requests in order; rq[t] holds the
  // responses each responder (2 = error responder) still owes, with due cycle.
  task automatic test_random();
    rsp_t        rq [3][$];
    int          oq [$];
    int          t, h;
    logic        acc, eg, erv;
    logic [31:0] ed;
    rsp_t        r;
    idle();
    for (int c = 0; c < 700; c++) begin
      if (c < 600 && $urandom_range(0, 2) != 0) drive_req(1'($urandom_range(0, 1)), pick_addr());
      else mreq = '0;
      for (int p = 0; p < 2; p++) begin
        sresp[p].gnt    = ($urandom_range(0, 3) != 0);
        sresp[p].rvalid = 1'b0;
        sresp[p].rdata  = $urandom;
        if (rq[p].size() > 0) begin
          if (rq[p][0].due <= c) begin
            sresp[p].rvalid = 1'b1;
            sresp[p].rdata  = rq[p][0].data;
          end
        end
      end
      #1;
      t   = model_tgt(mreq.addr);
      acc = mreq.req && (oq.size() < int'(MAXO)) && (oq.size() == 0 || oq[0] == t);
      eg  = acc;
      if (acc && t < 2) eg = sresp[t].gnt;
      erv = 1'b0;
      ed  = '0;
      h   = 0;
      if (oq.size() > 0) begin
        h = oq[0];
        if (rq[h].size() > 0) begin
          if (rq[h][0].due <= c) begin erv = 1'b1; ed = rq[h][0].data; end
        end
      end
      n_cmp++; if (mresp.gnt !== eg) begin n_err++; $display("FAIL rnd_gnt c=%0d: got %b want %b", c, mresp.gnt, eg); end
      n_cmp++; if (mresp.rvalid !== erv) begin n_err++; $display("FAIL rnd_rvalid c=%0d: got %b want %b", c, mresp.rvalid, erv); end
      if (erv) begin
        n_cmp++; if (mresp.rdata !== ed) begin n_err++; $display("FAIL rnd_rdata c=%0d: got %h want %h", c, mresp.rdata, ed); end
      end
      n_cmp++; if (uerr !== (eg && t == 2)) begin n_err++; $display("FAIL rnd_uerr c=%0d: got %b want %b", c, uerr, eg && t == 2); end
      for (int p = 0; p < 2; p++) begin
        n_cmp++; if (sreq[p].req !== (acc && t == p)) begin n_err++; $display("FAIL rnd_sreq%0d c=%0d: got %b want %b", p, c, sreq[p].req, acc && t == p); end
      end
      if (acc && t < 2) begin
        n_cmp++; if (sreq[t].addr !== mreq.addr || sreq[t].we !== mreq.we) begin n_err++; $display("FAIL rnd_fwd c=%0d: got %h/%b want %h/%b", c, sreq[t].addr, sreq[t].we, mreq.addr, mreq.we); end
      end
      if (erv) begin
        void'(oq.pop_front());
        void'(rq[h].pop_front());
      end
      if (eg) begin
        r.data = (t == 2) ? OBI_ERR_RDATA : 32'($urandom);
        r.due  = (t == 2) ? c + 1 : c + int'($urandom_range(1, 4));
        rq[t].push_back(r);
        oq.push_back(t);
      end
      next_cycle();
    end
    n_cmp++; if (oq.size() != 0) begin n_err++; $display("FAIL rnd_drain: %0d requests still outstanding, want 0", oq.size()); end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_target_switch();
    test_unmapped();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
